inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 101 ++++++++++
 tb/tb_inst_fetch.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch unit: BOOT/FETCH/HALT sequencer, program counter and a small
// FIFO of {pc, inst} pairs feeding decode via a valid/ready handshake.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ce,
    output logic [31:0] addr,
    input  logic [31:0] inst,
    input  logic        halt,
    input  logic        br_flag,
    input  logic [31:0] br_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;

    state_t          state_reg;
    logic [31:0]     pc_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic [31:0]     q_pc   [QDEPTH];
    logic [31:0]     q_inst [QDEPTH];

    logic pop;
    logic push_ok;
    logic redirect;

    assign pop      = if_valid & if_ready;
    // A full queue still accepts a fetch when decode drains the head this cycle.
    assign push_ok  = (count_reg < CW'(QDEPTH)) || ((count_reg == CW'(QDEPTH)) && pop);
    assign redirect = br_flag && (state_reg != BOOT);
    assign ce       = (state_reg == FETCH) && !halt && !br_flag && push_ok;
    assign addr     = pc_reg;

    assign if_valid = (count_reg != '0);
    assign if_inst  = q_inst[rd_ptr_reg];
    assign if_pc    = q_pc[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (redirect)
            count_next = '0;
        else
            count_next = count_reg + CW'(ce) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= BOOT;
        end else begin
            case (state_reg)
                BOOT:    state_reg <= halt ? HALT : FETCH;
                FETCH:   if (halt)  state_reg <= HALT;
                HALT:    if (!halt) state_reg <= FETCH;
                default: state_reg <= BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg     <= RESET_PC;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (redirect) begin
                // A same-cycle handshake is still counted by decode; the flush drops it.
                pc_reg     <= {br_target[31:2], 2'b00};
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (ce) begin
                    pc_reg     <= pc_reg + 32'd4;
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                end
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Payload storage carries no reset; validity is tracked by count_reg alone.
    always_ff @(posedge clk) begin
        if (ce) begin
            q_pc[wr_ptr_reg]   <= pc_reg;
            q_inst[wr_ptr_reg] <= inst;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: default, wrap-around RESET_PC and 4-deep variants
// share control stimulus; each memory returns 32'h1000_0000 + word index.
module tb_inst_fetch;
    logic        clk;
    logic        rst;
    logic        halt;
    logic        br_flag;
    logic [31:0] br_target;
    logic        if_ready;

    logic        ce_a, ce_b, ce_c;
    logic [31:0] addr_a, addr_b, addr_c;
    logic [31:0] inst_a, inst_b, inst_c;
    logic        if_valid_a, if_valid_b, if_valid_c;
    logic [31:0] if_inst_a, if_inst_b, if_inst_c;
    logic [31:0] if_pc_a, if_pc_b, if_pc_c;

    int n_checks;
    int n_fail;

    assign inst_a = 32'h1000_0000 + (addr_a >> 2);
    assign inst_b = 32'h1000_0000 + (addr_b >> 2);
    assign inst_c = 32'h1000_0000 + (addr_c >> 2);

    inst_fetch dut_a (
        .clk(clk), .rst(rst), .ce(ce_a), .addr(addr_a), .inst(inst_a),
        .halt(halt), .br_flag(br_flag), .br_target(br_target),
        .if_valid(if_valid_a), .if_ready(if_ready), .if_inst(if_inst_a), .if_pc(if_pc_a)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk(clk), .rst(rst), .ce(ce_b), .addr(addr_b), .inst(inst_b),
        .halt(halt), .br_flag(br_flag), .br_target(br_target),
        .if_valid(if_valid_b), .if_ready(if_ready), .if_inst(if_inst_b), .if_pc(if_pc_b)
    );

    inst_fetch #(.QDEPTH(4)) dut_c (
        .clk(clk), .rst(rst), .ce(ce_c), .addr(addr_c), .inst(inst_c),
        .halt(halt), .br_flag(br_flag), .br_target(br_target),
        .if_valid(if_valid_c), .if_ready(if_ready), .if_inst(if_inst_c), .if_pc(if_pc_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one tick into the BOOT cycle that follows reset release.
    task automatic do_reset();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (ce_a !== 1'b0) begin n_fail++; $display("FAIL reset_ce got %b want 0", ce_a); end
        n_checks++;
        if (if_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", if_valid_a); end
        n_checks++;
        if (addr_a !== 32'h0) begin n_fail++; $display("FAIL reset_addr_a got %h want 00000000", addr_a); end
        n_checks++;
        if (addr_b !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL reset_addr_b got %h want fffffff8", addr_b); end
        n_checks++;
        if (ce_c !== 1'b0 || if_valid_c !== 1'b0) begin
            n_fail++; $display("FAIL reset_c got ce=%b valid=%b want 0 0", ce_c, if_valid_c);
        end
        next_cycle();
        rst = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        @(negedge clk);
        n_checks++;
        if (ce_a !== 1'b0) begin n_fail++; $display("FAIL boot_ce got %b want 0", ce_a); end
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            @(negedge clk);
            n_checks++;
            if (ce_a !== 1'b1 || addr_a !== 32'(4 * k)) begin
                n_fail++; $display("FAIL seq_fetch k=%0d got ce=%b addr=%h want 1 %h", k, ce_a, addr_a, 32'(4 * k));
            end
            n_checks++;
            if (if_valid_a !== (k > 0)) begin
                n_fail++; $display("FAIL seq_valid k=%0d got %b want %b", k, if_valid_a, (k > 0));
            end
            if (k > 0) begin
                n_checks++;
                if (if_pc_a !== 32'(4 * (k - 1)) || if_inst_a !== 32'h1000_0000 + 32'(k - 1)) begin
                    n_fail++; $display("FAIL seq_head k=%0d got pc=%h inst=%h want %h %h", k, if_pc_a, if_inst_a,
                                       32'(4 * (k - 1)), 32'h1000_0000 + 32'(k - 1));
                end
            end
        end
        $display("test_sequential done");
    endtask

    task automatic test_backpressure();
        logic        exp_ce;
        logic [31:0] exp_addr;
        logic        exp_ce_c;
        logic [31:0] exp_addr_c;
        if_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            exp_ce     = (c == 1) || (c == 2);
            exp_addr   = (c <= 1) ? 32'h0 : (c == 2) ? 32'h4 : 32'h8;
            exp_ce_c   = (c >= 1) && (c <= 4);
            exp_addr_c = (c <= 1) ? 32'h0 : 32'(4 * ((c - 1 > 4) ? 4 : c - 1));
            n_checks++;
            if (ce_a !== exp_ce || addr_a !== exp_addr) begin
                n_fail++; $display("FAIL bp_fetch c=%0d got ce=%b addr=%h want %b %h", c, ce_a, addr_a, exp_ce, exp_addr);
            end
            n_checks++;
            if (ce_c !== exp_ce_c || addr_c !== exp_addr_c) begin
                n_fail++; $display("FAIL bp_fetch_q4 c=%0d got ce=%b addr=%h want %b %h", c, ce_c, addr_c, exp_ce_c, exp_addr_c);
            end
        end
        next_cycle();
        if_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ce_a !== 1'b1 || addr_a !== 32'h8 || if_valid_a !== 1'b1 || if_pc_a !== 32'h0) begin
            n_fail++; $display("FAIL bp_release got ce=%b addr=%h valid=%b pc=%h want 1 00000008 1 00000000",
                               ce_a, addr_a, if_valid_a, if_pc_a);
        end
        n_checks++;
        if (ce_c !== 1'b1 || addr_c !== 32'h10 || if_pc_c !== 32'h0) begin
            n_fail++; $display("FAIL bp_release_q4 got ce=%b addr=%h pc=%h want 1 00000010 00000000", ce_c, addr_c, if_pc_c);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (ce_a !== 1'b1 || addr_a !== 32'hC || if_pc_a !== 32'h4) begin
            n_fail++; $display("FAIL bp_after got ce=%b addr=%h pc=%h want 1 0000000c 00000004", ce_a, addr_a, if_pc_a);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_branch();
        next_cycle();
        if_ready = 1'b0;
        next_cycle();
        br_flag   = 1'b1;
        br_target = 32'h0000_0042;
        @(negedge clk);
        n_checks++;
        if (ce_a !== 1'b0 || if_valid_a !== 1'b1) begin
            n_fail++; $display("FAIL br_cycle got ce=%b valid=%b want 0 1", ce_a, if_valid_a);
        end
        next_cycle();
        br_flag = 1'b0;
        @(negedge clk);
        n_checks++;
        if (if_valid_a !== 1'b0 || addr_a !== 32'h40 || ce_a !== 1'b1) begin
            n_fail++; $display("FAIL br_after got valid=%b addr=%h ce=%b want 0 00000040 1", if_valid_a, addr_a, ce_a);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (if_valid_a !== 1'b1 || if_pc_a !== 32'h40 || if_inst_a !== 32'h1000_0010 || addr_a !== 32'h44) begin
            n_fail++; $display("FAIL br_head got valid=%b pc=%h inst=%h addr=%h want 1 00000040 10000010 00000044",
                               if_valid_a, if_pc_a, if_inst_a, addr_a);
        end
        $display("test_branch done");
    endtask

    task automatic test_halt();
        if_ready = 1'b1;
        do_reset();
        next_cycle();
        next_cycle();
        next_cycle();
        halt = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ce_a !== 1'b0 || if_valid_a !== 1'b1 || if_pc_a !== 32'h4 || if_inst_a !== 32'h1000_0001 || addr_a !== 32'h8) begin
            n_fail++; $display("FAIL halt_enter got ce=%b valid=%b pc=%h inst=%h addr=%h want 0 1 00000004 10000001 00000008",
                               ce_a, if_valid_a, if_pc_a, if_inst_a, addr_a);
        end
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            @(negedge clk);
            n_checks++;
            if (if_valid_a !== 1'b0 || ce_a !== 1'b0 || addr_a !== 32'h8) begin
                n_fail++; $display("FAIL halt_drained c=%0d got valid=%b ce=%b addr=%h want 0 0 00000008", c, if_valid_a, ce_a, addr_a);
            end
        end
        next_cycle();
        halt = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ce_a !== 1'b0) begin n_fail++; $display("FAIL halt_exit_cycle got ce=%b want 0", ce_a); end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (ce_a !== 1'b1 || addr_a !== 32'h8) begin
            n_fail++; $display("FAIL halt_resume got ce=%b addr=%h want 1 00000008", ce_a, addr_a);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (if_valid_a !== 1'b1 || if_pc_a !== 32'h8) begin
            n_fail++; $display("FAIL halt_resume_head got valid=%b pc=%h want 1 00000008", if_valid_a, if_pc_a);
        end
        $display("test_halt done");
    endtask

    task automatic test_reset_mid();
        next_cycle();
        if_ready = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (ce_a !== 1'b0 || if_valid_a !== 1'b0 || addr_a !== 32'h0 || addr_b !== 32'hFFFF_FFF8) begin
            n_fail++; $display("FAIL mid_reset got ce=%b valid=%b addr_a=%h addr_b=%h want 0 0 00000000 fffffff8",
                               ce_a, if_valid_a, addr_a, addr_b);
        end
        n_checks++;
        if (if_valid_c !== 1'b0) begin n_fail++; $display("FAIL mid_reset_q4 got valid=%b want 0", if_valid_c); end
        next_cycle();
        rst      = 1'b1;
        if_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ce_a !== 1'b0) begin n_fail++; $display("FAIL mid_boot got ce=%b want 0", ce_a); end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (ce_a !== 1'b1 || addr_a !== 32'h0) begin
            n_fail++; $display("FAIL mid_restart got ce=%b addr=%h want 1 00000000", ce_a, addr_a);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (if_valid_a !== 1'b1 || if_pc_a !== 32'h0) begin
            n_fail++; $display("FAIL mid_head got valid=%b pc=%h want 1 00000000", if_valid_a, if_pc_a);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr;
        if_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            @(negedge clk);
            exp_addr = 32'hFFFF_FFF8 + 32'(4 * k);
            n_checks++;
            if (ce_b !== 1'b1 || addr_b !== exp_addr) begin
                n_fail++; $display("FAIL wrap_addr k=%0d got ce=%b addr=%h want 1 %h", k, ce_b, addr_b, exp_addr);
            end
            if (k > 0) begin
                n_checks++;
                if (if_valid_b !== 1'b1 || if_pc_b !== exp_addr - 32'd4) begin
                    n_fail++; $display("FAIL wrap_head k=%0d got valid=%b pc=%h want 1 %h", k, if_valid_b, if_pc_b, exp_addr - 32'd4);
                end
            end
        end
        $display("test_wrap done");
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        halt      = 1'b0;
        br_flag   = 1'b0;
        br_target = 32'h0;
        if_ready  = 1'b1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch();
        test_halt();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
